// File: rtl/shot_detector.sv
// Zapper shot detector: accepts trigger edges, scores hits against the duck
// centre, and sequences the screen-flash and cooldown windows in frame ticks.
module shot_detector #(
    parameter int          MAX_AMMO        = 3,
    parameter logic [9:0]  HIT_RADIUS      = 10'd16,
    parameter logic [15:0] HIT_POINTS      = 16'd500,
    parameter int          FLASH_FRAMES    = 4,
    parameter int          COOLDOWN_FRAMES = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        trigger,
    input  logic        round_start,
    input  logic [9:0]  crosshair_x,
    input  logic [9:0]  crosshair_y,
    input  logic [18:0] duck_center,
    input  logic        duck_dead,
    output logic        shot_fired,
    output logic        duck_hit,
    output logic        flash_active,
    output logic [1:0]  ammo,
    output logic        out_of_ammo,
    output logic [15:0] score
);

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        FLASH,
        COOLDOWN
    } state_t;

    localparam logic [1:0] AMMO_FULL  = 2'(MAX_AMMO);
    localparam logic [7:0] FLASH_LAST = 8'(FLASH_FRAMES - 1);
    localparam logic [7:0] COOL_LAST  = 8'(COOLDOWN_FRAMES - 1);

    state_t             state;
    logic               frame_clk_d;
    logic               trigger_d;
    logic               frame_tick;
    logic               trig_edge;
    logic [7:0]         frame_cnt;
    logic [9:0]         cx_q;
    logic [9:0]         cy_q;
    logic [9:0]         dx_q;
    logic [9:0]         dy_q;
    logic               dead_q;
    logic signed [10:0] diff_x;
    logic signed [10:0] diff_y;
    logic [10:0]        abs_x;
    logic [10:0]        abs_y;
    logic               hit;
    logic [16:0]        score_sum;

    assign frame_tick = frame_clk & ~frame_clk_d;
    assign trig_edge  = trigger & ~trigger_d;

    // Operands are latched, so late changes to the duck cannot alter a shot.
    always_comb begin
        diff_x    = $signed({1'b0, cx_q}) - $signed({1'b0, dx_q});
        diff_y    = $signed({1'b0, cy_q}) - $signed({1'b0, dy_q});
        abs_x     = diff_x[10] ? $unsigned(-diff_x) : $unsigned(diff_x);
        abs_y     = diff_y[10] ? $unsigned(-diff_y) : $unsigned(diff_y);
        hit       = !dead_q
                    && (abs_x <= {1'b0, HIT_RADIUS})
                    && (abs_y <= {1'b0, HIT_RADIUS});
        score_sum = {1'b0, score} + {1'b0, HIT_POINTS};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            ammo         <= AMMO_FULL;
            score        <= 16'd0;
            shot_fired   <= 1'b0;
            duck_hit     <= 1'b0;
            flash_active <= 1'b0;
            out_of_ammo  <= 1'b0;
            frame_clk_d  <= 1'b0;
            trigger_d    <= 1'b0;
            frame_cnt    <= 8'd0;
            cx_q         <= 10'd0;
            cy_q         <= 10'd0;
            dx_q         <= 10'd0;
            dy_q         <= 10'd0;
            dead_q       <= 1'b0;
        end else begin
            frame_clk_d <= frame_clk;
            trigger_d   <= trigger;
            shot_fired  <= 1'b0;
            duck_hit    <= 1'b0;
            if (round_start) begin
                state        <= IDLE;
                ammo         <= AMMO_FULL;
                out_of_ammo  <= (AMMO_FULL == 2'd0);
                flash_active <= 1'b0;
                frame_cnt    <= 8'd0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (trig_edge && ammo != 2'd0) begin
                            cx_q        <= crosshair_x;
                            cy_q        <= crosshair_y;
                            dx_q        <= duck_center[9:0];
                            dy_q        <= {1'b0, duck_center[18:10]};
                            dead_q      <= duck_dead;
                            shot_fired  <= 1'b1;
                            ammo        <= ammo - 2'd1;
                            out_of_ammo <= (ammo == 2'd1);
                            state       <= EVAL;
                        end
                    end
                    EVAL: begin
                        if (hit) begin
                            duck_hit <= 1'b1;
                            score    <= score_sum[16] ? 16'hFFFF
                                                      : score_sum[15:0];
                        end
                        frame_cnt    <= 8'd0;
                        flash_active <= 1'b1;
                        state        <= FLASH;
                    end
                    FLASH: begin
                        if (frame_tick) begin
                            if (frame_cnt == FLASH_LAST) begin
                                frame_cnt    <= 8'd0;
                                flash_active <= 1'b0;
                                state        <= COOLDOWN;
                            end else begin
                                frame_cnt <= frame_cnt + 8'd1;
                            end
                        end
                    end
                    COOLDOWN: begin
                        if (frame_tick) begin
                            if (frame_cnt == COOL_LAST) begin
                                frame_cnt <= 8'd0;
                                state     <= IDLE;
                            end else begin
                                frame_cnt <= frame_cnt + 8'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shot_detector.sv
// Directed bench for shot_detector: latency, hit radius, ammo, trigger
// edge handling, duck_dead latching, round_start and score saturation.
module tb_shot_detector;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic        trigger;
    logic        round_start;
    logic [9:0]  crosshair_x;
    logic [9:0]  crosshair_y;
    logic [18:0] duck_center;
    logic        duck_dead;
    logic        shot_fired;
    logic        duck_hit;
    logic        flash_active;
    logic [1:0]  ammo;
    logic        out_of_ammo;
    logic [15:0] score;
    logic        shot_fired2;
    logic        duck_hit2;
    logic        flash_active2;
    logic [1:0]  ammo2;
    logic        out_of_ammo2;
    logic [15:0] score2;

    int total = 0;
    int bad   = 0;
    int cnt;

    always #5 Clk = ~Clk;

    shot_detector dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .trigger(trigger), .round_start(round_start),
        .crosshair_x(crosshair_x), .crosshair_y(crosshair_y),
        .duck_center(duck_center), .duck_dead(duck_dead),
        .shot_fired(shot_fired), .duck_hit(duck_hit),
        .flash_active(flash_active), .ammo(ammo),
        .out_of_ammo(out_of_ammo), .score(score)
    );

    shot_detector #(.HIT_POINTS(16'hFFF0)) dut_sat (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .trigger(trigger), .round_start(round_start),
        .crosshair_x(crosshair_x), .crosshair_y(crosshair_y),
        .duck_center(duck_center), .duck_dead(duck_dead),
        .shot_fired(shot_fired2), .duck_hit(duck_hit2),
        .flash_active(flash_active2), .ammo(ammo2),
        .out_of_ammo(out_of_ammo2), .score(score2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            frame_clk = 1'b1;
            step();
            frame_clk = 1'b0;
            step();
        end
    endtask

    task automatic shoot(input string tag, input logic [9:0] x,
                         input logic [9:0] y, input logic exp_shot,
                         input logic exp_hit);
        crosshair_x = x;
        crosshair_y = y;
        trigger = 1'b1;
        step();
        chk({tag, "_shot"}, 32'(shot_fired), 32'(exp_shot));
        trigger = 1'b0;
        step();
        chk({tag, "_hit"}, 32'(duck_hit), 32'(exp_hit));
        step();
    endtask

    initial begin
        Reset       = 1'b1;
        frame_clk   = 1'b0;
        trigger     = 1'b0;
        round_start = 1'b0;
        crosshair_x = 10'd0;
        crosshair_y = 10'd0;
        duck_center = {9'd240, 10'd320};
        duck_dead   = 1'b0;
        step();
        step();
        Reset = 1'b0;
        step();
        chk("rst_ammo", 32'(ammo), 32'd3);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_flags", {29'd0, shot_fired, duck_hit, flash_active}, 32'd0);
        chk("rst_ooa", 32'(out_of_ammo), 32'd0);

        // Shot 1: exact centre, explicit latency checks.
        crosshair_x = 10'd320;
        crosshair_y = 10'd240;
        trigger = 1'b1;
        step();
        chk("s1_shot", 32'(shot_fired), 32'd1);
        chk("s1_nohit_yet", 32'(duck_hit), 32'd0);
        chk("s1_ammo", 32'(ammo), 32'd2);
        trigger = 1'b0;
        step();
        chk("s1_hit", 32'(duck_hit), 32'd1);
        chk("s1_shot_off", 32'(shot_fired), 32'd0);
        chk("s1_score", 32'(score), 32'd500);
        chk("s1_flash", 32'(flash_active), 32'd1);
        chk("sat_first", 32'(score2), 32'h0000FFF0);
        step();
        chk("s1_hit_off", 32'(duck_hit), 32'd0);
        ticks(3);
        chk("s1_flash3", 32'(flash_active), 32'd1);
        ticks(1);
        chk("s1_flash4", 32'(flash_active), 32'd0);
        ticks(7);
        trigger = 1'b1;
        step();
        chk("s1_cool_ign", 32'(shot_fired), 32'd0);
        trigger = 1'b0;
        step();
        ticks(1);

        // Shot 2: inclusive radius corner, saturation on the override.
        shoot("s2", 10'd336, 10'd256, 1'b1, 1'b1);
        chk("s2_score", 32'(score), 32'd1000);
        chk("s2_ammo", 32'(ammo), 32'd1);
        chk("sat_clamp", 32'(score2), 32'h0000FFFF);
        ticks(12);

        // Shot 3: one pixel outside.
        shoot("s3", 10'd337, 10'd240, 1'b1, 1'b0);
        chk("s3_score", 32'(score), 32'd1000);
        chk("s3_ammo", 32'(ammo), 32'd0);
        chk("s3_ooa", 32'(out_of_ammo), 32'd1);
        ticks(12);

        shoot("s4_empty", 10'd320, 10'd240, 1'b0, 1'b0);
        chk("s4_ammo", 32'(ammo), 32'd0);

        round_start = 1'b1;
        step();
        round_start = 1'b0;
        chk("rs_ammo", 32'(ammo), 32'd3);
        chk("rs_ooa", 32'(out_of_ammo), 32'd0);
        chk("rs_score", 32'(score), 32'd1000);

        // Held trigger for 1000 cycles, frame ticks running.
        crosshair_x = 10'd0;
        crosshair_y = 10'd0;
        cnt = 0;
        trigger = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            frame_clk = ((i % 4) >= 2);
            step();
            if (shot_fired) cnt++;
        end
        trigger = 1'b0;
        frame_clk = 1'b0;
        repeat (3) begin
            step();
            if (shot_fired) cnt++;
        end
        chk("held_once", 32'(cnt), 32'd1);
        chk("held_ammo", 32'(ammo), 32'd2);

        // Re-pulses during FLASH/COOLDOWN are dropped, not queued.
        shoot("rp", 10'd0, 10'd0, 1'b1, 1'b0);
        cnt = 0;
        for (int j = 0; j < 12; j++) begin
            trigger = 1'b1;
            step();
            if (shot_fired) cnt++;
            trigger = 1'b0;
            step();
            if (shot_fired) cnt++;
            ticks(1);
        end
        repeat (5) begin
            step();
            if (shot_fired) cnt++;
        end
        chk("rp_none", 32'(cnt), 32'd0);
        chk("rp_ammo", 32'(ammo), 32'd1);

        round_start = 1'b1;
        step();
        round_start = 1'b0;

        // Dead duck at latch: miss.
        duck_dead = 1'b1;
        shoot("dead", 10'd320, 10'd240, 1'b1, 1'b0);
        duck_dead = 1'b0;
        chk("dead_score", 32'(score), 32'd1000);
        ticks(12);

        // Duck dies / moves after latch: still a hit.
        crosshair_x = 10'd320;
        crosshair_y = 10'd240;
        trigger = 1'b1;
        step();
        chk("late_shot", 32'(shot_fired), 32'd1);
        duck_dead = 1'b1;
        duck_center = {9'd10, 10'd900};
        trigger = 1'b0;
        step();
        chk("late_hit", 32'(duck_hit), 32'd1);
        chk("late_score", 32'(score), 32'd1500);
        duck_dead = 1'b0;
        duck_center = {9'd240, 10'd320};
        step();
        ticks(12);

        // round_start during EVAL cancels the hit.
        trigger = 1'b1;
        step();
        chk("rse_shot", 32'(shot_fired), 32'd1);
        chk("rse_ammo0", 32'(ammo), 32'd0);
        round_start = 1'b1;
        trigger = 1'b0;
        step();
        round_start = 1'b0;
        chk("rse_nohit", 32'(duck_hit), 32'd0);
        chk("rse_ammo", 32'(ammo), 32'd3);
        chk("rse_flash", 32'(flash_active), 32'd0);
        chk("rse_score", 32'(score), 32'd1500);
        step();
        shoot("rse_idle", 10'd320, 10'd240, 1'b1, 1'b1);
        chk("rse_score2", 32'(score), 32'd2000);

        // Reset mid-flash restores everything.
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("mid_rst_score", 32'(score), 32'd0);
        chk("mid_rst_ammo", 32'(ammo), 32'd3);
        chk("mid_rst_flash", 32'(flash_active), 32'd0);
        step();
        shoot("post_rst", 10'd320, 10'd240, 1'b1, 1'b1);
        chk("post_rst_score", 32'(score), 32'd500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shot_detector.md
Name: shot_detector

Overview:
- Downstream consumer of the duck sprite block: turns a zapper trigger plus the crosshair position into shot events and decides whether each shot hit the duck.
- Compares the latched crosshair against the packed duck_center and the duck_dead flag.
- Emits a one-cycle duck_hit pulse back to the duck logic, and keeps ammo and score for the HUD.
- Drives a flash window, counted in frames, for the screen-flash effect.

Parameters:
- MAX_AMMO, 3, shots per round; loaded on reset and on round_start (1..3).
- HIT_RADIUS, 10'd16, max |dx| and |dy| in pixels for a hit (inclusive).
- HIT_POINTS, 16'd500, score added per hit.
- FLASH_FRAMES, 4, frame ticks flash_active stays high (>=1).
- COOLDOWN_FRAMES, 8, frame ticks after flash before the next shot is accepted (>=1).

Ports:
- Clk  in  1  50 MHz system clock
- Reset  in  1  synchronous, active-high reset
- frame_clk  in  1  frame strobe (~60 Hz), level signal; rising edge detected internally
- trigger  in  1  zapper trigger, active-high level
- round_start  in  1  one-cycle pulse: reload ammo, abort any shot in progress
- crosshair_x  in  10  crosshair X pixel
- crosshair_y  in  10  crosshair Y pixel
- duck_center  in  19  packed duck centre: [9:0] = X, [18:10] = Y (Y zero-extended to 10 bits for compare)
- duck_dead  in  1  duck already dead; any shot is a miss
- shot_fired  out  1  one-cycle pulse per accepted shot
- duck_hit  out  1  one-cycle pulse, one cycle after shot_fired, when the shot hits
- flash_active  out  1  high during FLASH state
- ammo  out  2  shots remaining
- out_of_ammo  out  1  ammo == 0
- score  out  16  running score, saturating

Behaviour:
- Reset (sync): state=IDLE; ammo=MAX_AMMO; score=0; shot_fired=0; duck_hit=0; flash_active=0; out_of_ammo=0; frame/trigger edge registers=0; frame counter=0.
- frame_tick = frame_clk & ~frame_clk_d. trig_edge = trigger & ~trigger_d. Both delay flops are registered every cycle.
- A held trigger fires at most once. A new shot needs trigger low for at least one cycle.
- States: IDLE, EVAL, FLASH, COOLDOWN.
- IDLE, trig_edge and ammo != 0:
  - Latch crosshair_x, crosshair_y, duck_center and duck_dead.
  - Assert shot_fired for the next cycle.
  - Decrement ammo on the same edge.
  - Go to EVAL.
- IDLE, trig_edge and ammo == 0: no pulse, no ammo change, stay IDLE.
- EVAL, exactly one cycle:
  - Compute hit = !dead_latched && |cx - dx| <= HIT_RADIUS && |cy - dy| <= HIT_RADIUS.
  - Use 11-bit signed differences and take absolute values.
  - If hit: duck_hit=1 for that cycle; score += HIT_POINTS, saturating at 16'hFFFF.
  - Then go to FLASH with the frame counter cleared.
- FLASH: flash_active=1. Counter increments on each frame_tick. After FLASH_FRAMES ticks, clear the counter and go to COOLDOWN.
- COOLDOWN: after COOLDOWN_FRAMES ticks, go to IDLE.
- trig_edge in EVAL, FLASH or COOLDOWN is ignored and not queued.
- Latency: trigger first sampled high at edge k → shot_fired high cycle k+1 → duck_hit high cycle k+2. Score and ammo are visible at the edges that start those cycles.
- round_start has priority over everything except Reset:
  - ammo=MAX_AMMO; state=IDLE; flash_active=0; counter=0.
  - Suppresses any shot_fired or duck_hit pending that edge; a same-cycle trig_edge is ignored.
  - score is unchanged.
- Reset in mid-shot fully restores reset values, including score=0.
- duck_center or duck_dead changing after the latch edge does not affect the in-flight evaluation.
- out_of_ammo is registered and tracks ammo==0 in the same cycle ammo changes.

Test Plan:
- Reset, trigger rising with crosshair (320,240), duck_center X=320 Y=240, duck_dead=0 → shot_fired at k+1; duck_hit at k+2; ammo 3→2; score 0→500; flash_active for 4 frame ticks, then COOLDOWN 8 ticks.
- Crosshair (336,256) vs duck (320,240) → hit (boundary inclusive). Crosshair (337,240) → shot_fired, no duck_hit, score unchanged, ammo decrements.
- Three shots spaced past cooldown, then a fourth trigger → ammo 0, out_of_ammo=1, fourth produces no shot_fired; round_start → ammo=3, out_of_ammo=0, score retained.
- Trigger held high 1000 cycles, and re-pulsed during FLASH/COOLDOWN → exactly one shot_fired; no queued shot afterwards.
- On-target shot with duck_dead=1 at latch → shot_fired, no duck_hit. Separately, duck_dead rises the cycle after latch with target on → duck_hit still asserted.
- Score preset near max (many hits, HIT_POINTS=16'hFFF0 override), next hit → score=16'hFFFF. round_start asserted during EVAL cycle → no duck_hit, state IDLE, ammo=MAX_AMMO.
